// File: rtl/tri_geom_pkg.sv
// Shared geometry types and width helpers for the triangle side-length datapath.
package tri_geom_pkg;

  typedef enum logic [2:0] {IDLE, SQX, SQY, ROOT, DONE} tri_state_e;
  typedef enum logic [1:0] {AB, BC, CA} side_idx_e;

  // Differences never overflow at W+1 bits; two squares of those fit in 2W+1.
  function automatic int diff_w(input int w);
    return w + 1;
  endfunction

  function automatic int norm_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int root_w(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/isqrt_iter.sv
// Restoring integer square root, one result bit per cycle, MSB first.
// The first bit is resolved on the start edge so done pulses exactly RW cycles after start.
module isqrt_iter #(
  parameter int NW = 17,
  parameter int RW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] radicand,
  output logic [RW-1:0] root,
  output logic          done
);

  localparam int PW = 2 * RW;
  localparam int MW = RW + 2;
  localparam int CW = $clog2(RW + 1);

  logic [PW-1:0]    rad_pad;
  logic [PW-1:0]    rad_sh;
  logic [MW-1:0]    rem;
  logic [RW-1:0]    q;
  logic [CW-1:0]    cnt;
  logic [MW-1:0]    rem_in;
  logic [RW-1:0]    q_in;
  logic [1:0]       pair;
  logic [MW+RW-1:0] nxt;

  // One restoring step: bring down two radicand bits, try appending a 1 to the root.
  function automatic logic [MW+RW-1:0] step(input logic [MW-1:0] r,
                                            input logic [RW-1:0] qq,
                                            input logic [1:0]    pr);
    logic [MW+1:0] rs;
    logic [MW+1:0] trial;
    rs    = {r, pr};
    trial = {2'b00, qq, 2'b01};
    if (rs >= trial)
      return {MW'(rs - trial), qq[RW-2:0], 1'b1};
    else
      return {MW'(rs), qq[RW-2:0], 1'b0};
  endfunction

  assign rad_pad = PW'(radicand);
  assign rem_in  = start ? '0 : rem;
  assign q_in    = start ? '0 : q;
  assign pair    = start ? rad_pad[PW-1 -: 2] : rad_sh[PW-1 -: 2];
  assign nxt     = step(rem_in, q_in, pair);
  assign root    = q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        cnt <= CW'(RW - 1);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1))
          done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start || cnt != '0) begin
      {rem, q} <= nxt;
      rad_sh   <= (start ? rad_pad : rad_sh) << 2;
    end
  end

endmodule

// File: rtl/tri_side_seq.sv
// Sequential triangle side-length unit: one shared squarer/accumulator and one
// iterative square root time-shared across sides AB, BC and CA.
module tri_side_seq
  import tri_geom_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] ax,
  input  logic [W-1:0] ay,
  input  logic [W-1:0] bx,
  input  logic [W-1:0] by,
  input  logic [W-1:0] cx,
  input  logic [W-1:0] cy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   side_ab,
  output logic [W:0]   side_bc,
  output logic [W:0]   side_ca,
  output logic         busy
);

  localparam int DW = diff_w(W);
  localparam int NW = norm_w(W);
  localparam int RW = root_w(W);

  tri_state_e state, state_nxt;
  side_idx_e  idx;

  logic signed [W-1:0]  ax_r, ay_r, bx_r, by_r, cx_r, cy_r;
  logic signed [DW-1:0] dx, dy, op;
  logic signed [NW-1:0] op_ext;
  logic [NW-1:0]        sq;
  logic [NW-1:0]        sum;
  logic [NW-1:0]        acc;
  logic                 start;
  logic [RW-1:0]        root;
  logic                 rdone;

  function automatic logic signed [DW-1:0] sdiff(input logic signed [W-1:0] p,
                                                 input logic signed [W-1:0] m);
    return {p[W-1], p} - {m[W-1], m};
  endfunction

  // Operand select: difference vector of the current side, x in SQX and y in SQY.
  always_comb begin
    dx = sdiff(bx_r, ax_r);
    dy = sdiff(by_r, ay_r);
    case (idx)
      BC: begin
        dx = sdiff(cx_r, bx_r);
        dy = sdiff(cy_r, by_r);
      end
      CA: begin
        dx = sdiff(ax_r, cx_r);
        dy = sdiff(ay_r, cy_r);
      end
      default: ;
    endcase
  end

  assign op     = (state == SQY) ? dy : dx;
  assign op_ext = {{(NW-DW){op[DW-1]}}, op};
  assign sq     = op_ext * op_ext;
  assign sum    = acc + sq;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign start     = (state == SQY);

  isqrt_iter #(
    .NW (NW),
    .RW (RW)
  ) u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .radicand (sum),
    .root     (root),
    .done     (rdone)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SQX;
      SQX:     state_nxt = SQY;
      SQY:     state_nxt = ROOT;
      ROOT:    if (rdone)     state_nxt = (idx == CA) ? DONE : SQX;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= AB;
      acc     <= '0;
      side_ab <= '0;
      side_bc <= '0;
      side_ca <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) idx <= AB;
        SQX:  acc <= sq;
        SQY:  acc <= sum;
        ROOT: begin
          if (rdone) begin
            case (idx)
              AB:      side_ab <= root;
              BC:      side_bc <= root;
              default: side_ca <= root;
            endcase
            if (idx != CA)
              idx <= side_idx_e'(idx + 2'd1);
          end
        end
        default: ;
      endcase
    end
  end

  // Vertex capture happens only on the accept edge.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      ax_r <= ax;
      ay_r <= ay;
      bx_r <= bx;
      by_r <= by;
      cx_r <= cx;
      cy_r <= cy;
    end
  end

endmodule

// File: doc/tri_side_seq.md
# tri_side_seq

Sequential controller that computes the three side lengths of a triangle from its vertex coordinates A, B and C. It time-shares one squarer/accumulator and one iterative integer square-root unit across sides AB, BC and CA. It replaces the parallel subtract/transpose/dot/distance chain in the geometry datapath, trading latency for a single multiplier. Vertices enter through a valid/ready handshake, and the three floor-rounded lengths leave through a second valid/ready handshake.

## Interface
- `W`, default 8: signed coordinate width.
- Derived, not overridable: difference width `DW = W+1`; squared-norm width `NW = 2*W+1`; root width `RW = W+1`.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `in_valid`  in  1: vertex set is valid.
- `in_ready`  out  1: block can accept a vertex set; high only in IDLE.
- `ax, ay, bx, by, cx, cy`  in  W each, signed: vertex coordinates; sampled on the accept edge only.
- `out_valid`  out  1: side lengths are valid.
- `out_ready`  in  1: consumer accepts the results.
- `side_ab, side_bc, side_ca`  out  RW each, unsigned: floor(sqrt(dx²+dy²)) per side.
- `busy`  out  1: high in every state except IDLE.

## Operation
- **Accept.** An accept occurs on an edge where `in_valid & in_ready`. On accept, all six coordinates are registered and the FSM enters SQX with side index 0.
- **Side index.** Index 0 = AB (B−A), 1 = BC (C−B), 2 = CA (A−C).
- **Difference and square.** Differences are sign-extended to DW bits before subtraction, so no overflow is possible. Squares are unsigned and the accumulator is NW bits, so no saturation is needed.
- **FSM states:**
  - IDLE: `in_ready=1`; on accept go to SQX.
  - SQX: `acc <= dx*dx`; go to SQY.
  - SQY: `acc <= acc + dy*dy`; pulse `start` to the root unit; go to ROOT.
  - ROOT: wait for the root unit's `done`. On `done`, write the root into the selected side register. If index < 2, increment the index and go to SQX; otherwise go to DONE.
  - DONE: `out_valid=1`. On `out_ready`, go to IDLE.
- **Root unit.** Restoring, one result bit per cycle from MSB down. It takes exactly RW cycles from `start` to `done` (a one-cycle pulse). The result is an exact floor.
- **Output registers.** Side registers update only on ROOT `done` and are never cleared on accept. In DONE they hold stable until the handshake completes; after return to IDLE they keep the last values.
- **Input discipline.** Inputs are ignored outside IDLE, and `in_valid` is not required to be held low there.
- **Reset.** Reset is synchronous, active-low, and effective from any state, including mid-ROOT. It forces IDLE, index 0, `acc=0`, all side registers 0, and aborts the root unit.

## Timing
- **Reset values:** `in_ready=1`, `out_valid=0`, `busy=0`, `side_ab=side_bc=side_ca=0`.
- **Per side:** 1 (SQX) + 1 (SQY) + RW (ROOT) cycles.
- **Latency:** `out_valid` rises 3*(RW+2) cycles after the accept edge, which is 33 for W=8.
- **Throughput:** a new accept is possible at the earliest on the edge after the `out_valid & out_ready` edge (IDLE is one cycle). Accept and output handshakes never overlap.
- **Backpressure:** `out_ready` low holds DONE indefinitely; outputs and `out_valid` stay stable, and `in_ready` stays 0.
- **Reset versus handshake:** if reset and an accept or output handshake coincide, reset wins and no transaction is recorded.
- **Multiplier:** the single W×W multiplier is combinational within SQX/SQY; the muxed operand plus square plus add must fit in one cycle.

## Structure
- **Shared package `tri_geom_pkg`:**
  - `tri_state_e` (IDLE, SQX, SQY, ROOT, DONE);
  - `side_idx_e` (AB, BC, CA);
  - localparam functions for DW/NW/RW from W.
  - The existing geometry blocks reuse these constants.
- **Sub-module `isqrt_iter`:** parameters NW and RW; ports `clk`, `rst_n`, `start`, `radicand[NW]`, `root[RW]`, `done`. It is verified standalone (exhaustive for NW ≤ 17).
- **Top level:** the top holds the FSM, operand muxes, one multiplier, the accumulator and the side registers.

## Test plan
- **Reference triangle:** A(1,−1), B(−4,6), C(−3,−5), W=8 → `side_ab=8` (74), `side_bc=11` (122), `side_ca=5` (32); `out_valid` exactly 33 cycles after accept.
- **Extreme span:** A(−128,−128), B(127,127), C=A → `side_ab=360` (130050), `side_bc=360`, `side_ca=0`; no overflow.
- **Degenerate and perfect squares:** all vertices (5,5) → 0,0,0. Then A(0,0), B(3,4), C(0,4) → 5,3,4.
- **Backpressure:** hold `out_ready=0` for 20 cycles in DONE → outputs and `out_valid` stable, `in_ready=0`, extra `in_valid` pulses ignored. Then raise `out_ready` → IDLE next cycle and a back-to-back second triangle accepted.
- **Reset mid-operation:** drive `rst_n=0` for one cycle during BC ROOT → next cycle IDLE, `in_ready=1`, `busy=0`, all sides 0. A following triangle produces correct results with nominal latency.
- **Random regression:** 10k random signed vertex sets with random `out_ready` stalls → each side equals the scoreboard floor(sqrt(dx²+dy²)), with latency constant at 33.
